// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: buffers ALU commands in a small FIFO, issues them one at a time
// to an external combinational ALU and returns the captured result with flags.
`default_nettype none

module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         iClk,
  input  logic                         iRst_n,
  input  logic                         iCmdValid,
  output logic                         oCmdReady,
  input  logic [3:0]                   iCmdOp,
  input  logic [WIDTH-1:0]             iCmdA,
  input  logic [WIDTH-1:0]             iCmdB,
  output logic [WIDTH-1:0]             oAluA,
  output logic [WIDTH-1:0]             oAluB,
  output logic [3:0]                   oAluCtrl,
  input  logic [WIDTH-1:0]             iAluOut,
  input  logic                         iAluCarry,
  output logic                         oRspValid,
  input  logic                         iRspReady,
  output logic [WIDTH-1:0]             oRspData,
  output logic                         oRspCarry,
  output logic                         oRspZero,
  output logic                         oRspErr,
  output logic [$clog2(DEPTH+1)-1:0]   oCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  cmd_t             mem_q [DEPTH];
  cmd_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;

  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  cmd_t head;
  logic cap_err;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = iCmdValid & ~fifo_full;
  assign head       = mem_q[rd_ptr_q];
  assign cap_err    = (alu_ctrl_q > OP_DIV) | ((alu_ctrl_q == OP_DIV) & (alu_b_q == '0));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{op: iCmdOp, a: iCmdA, b: iCmdB};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          alu_a_d    = head.a;
          alu_b_d    = head.b;
          alu_ctrl_d = head.op;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Erroring commands ignore the ALU output entirely.
        rsp_valid_d = 1'b1;
        rsp_err_d   = cap_err;
        rsp_data_d  = cap_err ? '0 : iAluOut;
        rsp_carry_d = ~cap_err & (alu_ctrl_q == OP_ADD) & iAluCarry;
        rsp_zero_d  = ~cap_err & (iAluOut == '0);
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (iRspReady) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            alu_a_d    = head.a;
            alu_b_d    = head.b;
            alu_ctrl_d = head.op;
            state_d    = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign oCmdReady = ~fifo_full;
  assign oCount    = count_q;
  assign oAluA     = alu_a_q;
  assign oAluB     = alu_b_q;
  assign oAluCtrl  = alu_ctrl_q;
  assign oRspValid = rsp_valid_q;
  assign oRspData  = rsp_data_q;
  assign oRspCarry = rsp_carry_q;
  assign oRspZero  = rsp_zero_q;
  assign oRspErr   = rsp_err_q;

endmodule

`default_nettype wire
